// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares the one SDRAM command port among three requesters:
//   - the SPI pixel write path
//   - display read port 1
//   - display read port 2
//
// Each grant is a fixed burst of BURST_LEN words. A read port whose FIFO is
// running low ("urgent") is served first. Otherwise the ports take turns in
// round-robin order. Each grant issues one command and then counts data
// beats until the burst ends.
//
// Optional feature macro: ARB_WDOG_EN
//   Defined   : a transfer that stalls for WDOG_CYCLES cycles without a
//               beat is aborted, and oTimeout pulses for one cycle.
//   Undefined : oTimeout is tied low and a transfer waits indefinitely.
//
// Ports
//   iCLK, iRST_n             clock, asynchronous active-low reset
//   iWr_Req, iWr_Addr        write path request and burst start address
//   iRd_Req_1/2              read port wants a burst
//   iRd_Lvl_1/2              read FIFO fill level
//   iRd_Addr_1/2             read burst start address
//   oGnt                     one-hot grant: [0]=write [1]=rd1 [2]=rd2
//   oCmd_Valid, iCmd_Ready   command handshake to the SDRAM controller
//   oCmd_Write, oCmd_Addr    burst direction and start address
//   iBeat                    one data word moved this cycle
//   oBusy                    arbiter is not idle
//   oTimeout                 one-cycle pulse on a watchdog abort
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int BURST_LEN   = 8,
  parameter int ADDR_W      = 24,
  parameter int LVL_W       = 9,
  parameter int URGENT_LVL  = 64,
  parameter int WDOG_CYCLES = 256
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iWr_Req,
  input  logic [ADDR_W-1:0] iWr_Addr,
  input  logic              iRd_Req_1,
  input  logic [LVL_W-1:0]  iRd_Lvl_1,
  input  logic [ADDR_W-1:0] iRd_Addr_1,
  input  logic              iRd_Req_2,
  input  logic [LVL_W-1:0]  iRd_Lvl_2,
  input  logic [ADDR_W-1:0] iRd_Addr_2,
  output logic [2:0]        oGnt,
  output logic              oCmd_Valid,
  input  logic              iCmd_Ready,
  output logic              oCmd_Write,
  output logic [ADDR_W-1:0] oCmd_Addr,
  input  logic              iBeat,
  output logic              oBusy,
  output logic              oTimeout
);

  // Reject parameter values the beat counter and watchdog cannot support.
  if (BURST_LEN < 2 || BURST_LEN > 255 || WDOG_CYCLES < 1) begin : g_bad_param
    $error("sdram_port_arbiter: BURST_LEN or WDOG_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    CMD_S  = 2'd1,
    XFER_S = 2'd2
  } state_t;

  // Port indices. These are also the encodings stored in rr_ptr and last_rd.
  localparam logic [1:0]       WR_IDX     = 2'd0;
  localparam logic [1:0]       RD1_IDX    = 2'd1;
  localparam logic [1:0]       RD2_IDX    = 2'd2;
  localparam logic [7:0]       LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [LVL_W-1:0] URGENT_THR = LVL_W'(URGENT_LVL);

  // Round-robin pick.
  // The search starts at the port after ptr and wraps modulo 3.
  // The caller only uses the result when at least one request is set.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] first, second, third;
    case (ptr)
      2'd0:    {first, second, third} = {2'd1, 2'd2, 2'd0};
      2'd1:    {first, second, third} = {2'd2, 2'd0, 2'd1};
      2'd2:    {first, second, third} = {2'd0, 2'd1, 2'd2};
      default: {first, second, third} = {2'd1, 2'd2, 2'd0};
    endcase
    if (req[first]) begin
      rr_pick = first;
    end else if (req[second]) begin
      rr_pick = second;
    end else begin
      rr_pick = third;
    end
  endfunction

  state_t              state_r, state_s;
  logic [2:0]          gnt_r, gnt_s;
  logic                cmd_valid_r, cmd_valid_s;
  logic                cmd_write_r, cmd_write_s;
  logic [ADDR_W-1:0]   cmd_addr_r, cmd_addr_s;
  logic [1:0]          rr_ptr_r, rr_ptr_s;
  logic [1:0]          last_rd_r, last_rd_s;   // last read port granted (rd1 or rd2)
  logic [7:0]          beat_cnt_r, beat_cnt_s;
  logic [2:0]          req_vec_s;
  logic                urgent_1_s, urgent_2_s, any_req_s;
  logic [1:0]          win_idx_s;
  logic [2:0]          win_gnt_s;
  logic [ADDR_W-1:0]   win_addr_s;

`ifdef ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_r, wdog_s;
  logic              timeout_r, timeout_s;
`endif

  assign req_vec_s  = {iRd_Req_2, iRd_Req_1, iWr_Req};
  assign any_req_s  = |req_vec_s;
  assign urgent_1_s = iRd_Req_1 && (iRd_Lvl_1 < URGENT_THR);
  assign urgent_2_s = iRd_Req_2 && (iRd_Lvl_2 < URGENT_THR);

  // Pick the winner.
  // Urgent reads come first; when both are urgent, the read port not served last wins.
  always_comb begin
    win_idx_s = WR_IDX;
    if (urgent_1_s && urgent_2_s) begin
      if (last_rd_r == RD1_IDX) begin
        win_idx_s = RD2_IDX;
      end else begin
        win_idx_s = RD1_IDX;
      end
    end else if (urgent_1_s) begin
      win_idx_s = RD1_IDX;
    end else if (urgent_2_s) begin
      win_idx_s = RD2_IDX;
    end else begin
      win_idx_s = rr_pick(req_vec_s, rr_ptr_r);
    end
  end

  // Decode the winner into a one-hot grant and select its burst address.
  always_comb begin
    win_gnt_s  = 3'b001;
    win_addr_s = iWr_Addr;
    case (win_idx_s)
      WR_IDX:  begin win_gnt_s = 3'b001; win_addr_s = iWr_Addr;   end
      RD1_IDX: begin win_gnt_s = 3'b010; win_addr_s = iRd_Addr_1; end
      RD2_IDX: begin win_gnt_s = 3'b100; win_addr_s = iRd_Addr_2; end
      default: begin win_gnt_s = 3'b001; win_addr_s = iWr_Addr;   end
    endcase
  end

  // Next-state and next-output logic for the IDLE -> CMD -> XFER cycle.
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    cmd_valid_s = cmd_valid_r;
    cmd_write_s = cmd_write_r;
    cmd_addr_s  = cmd_addr_r;
    rr_ptr_s    = rr_ptr_r;
    last_rd_s   = last_rd_r;
    beat_cnt_s  = beat_cnt_r;
`ifdef ARB_WDOG_EN
    wdog_s      = wdog_r;
    timeout_s   = 1'b0;
`endif
    case (state_r)
      IDLE_S: begin
        if (any_req_s) begin
          state_s     = CMD_S;
          gnt_s       = win_gnt_s;
          cmd_valid_s = 1'b1;
          cmd_write_s = (win_idx_s == WR_IDX);
          cmd_addr_s  = win_addr_s;
          rr_ptr_s    = win_idx_s;
          if (win_idx_s != WR_IDX) begin
            last_rd_s = win_idx_s;
          end else begin
            last_rd_s = last_rd_r;
          end
        end else begin
          state_s = IDLE_S;
        end
      end
      CMD_S: begin
        // Beats seen here belong to no burst yet and are ignored.
        if (iCmd_Ready) begin
          state_s     = XFER_S;
          cmd_valid_s = 1'b0;
          beat_cnt_s  = 8'd0;
`ifdef ARB_WDOG_EN
          wdog_s      = '0;
`endif
        end else begin
          state_s = CMD_S;
        end
      end
      XFER_S: begin
        if (iBeat) begin
`ifdef ARB_WDOG_EN
          wdog_s = '0;
`endif
          if (beat_cnt_r == LAST_BEAT) begin
            state_s    = IDLE_S;
            gnt_s      = 3'b000;
            beat_cnt_s = 8'd0;
          end else begin
            beat_cnt_s = beat_cnt_r + 8'd1;
          end
        end else begin
`ifdef ARB_WDOG_EN
          // Abort the burst. rr_ptr keeps the aborted winner.
          if (wdog_r == WDOG_LAST) begin
            state_s    = IDLE_S;
            gnt_s      = 3'b000;
            beat_cnt_s = 8'd0;
            wdog_s     = '0;
            timeout_s  = 1'b1;
          end else begin
            wdog_s = wdog_r + {{(WDOG_W-1){1'b0}}, 1'b1};
          end
`else
          state_s = XFER_S;
`endif
        end
      end
      default: begin
        state_s     = IDLE_S;
        gnt_s       = 3'b000;
        cmd_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers. The asynchronous reset clears all outputs at once.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_r     <= IDLE_S;
      gnt_r       <= 3'b000;
      cmd_valid_r <= 1'b0;
      cmd_write_r <= 1'b0;
      cmd_addr_r  <= '0;
      rr_ptr_r    <= WR_IDX;
      last_rd_r   <= RD2_IDX;
      beat_cnt_r  <= 8'd0;
`ifdef ARB_WDOG_EN
      wdog_r      <= '0;
      timeout_r   <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      cmd_valid_r <= cmd_valid_s;
      cmd_write_r <= cmd_write_s;
      cmd_addr_r  <= cmd_addr_s;
      rr_ptr_r    <= rr_ptr_s;
      last_rd_r   <= last_rd_s;
      beat_cnt_r  <= beat_cnt_s;
`ifdef ARB_WDOG_EN
      wdog_r      <= wdog_s;
      timeout_r   <= timeout_s;
`endif
    end
  end

  assign oGnt       = gnt_r;
  assign oCmd_Valid = cmd_valid_r;
  assign oCmd_Write = cmd_write_r;
  assign oCmd_Addr  = cmd_addr_r;
  assign oBusy      = (state_r != IDLE_S);
`ifdef ARB_WDOG_EN
  assign oTimeout   = timeout_r;
`else
  assign oTimeout   = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

  localparam int BL = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, rd_req_1, rd_req_2, cmd_ready, beat;
  logic [23:0] wr_addr, rd_addr_1, rd_addr_2;
  logic [8:0]  rd_lvl_1, rd_lvl_2;
  logic [2:0]  gnt;
  logic        cmd_valid, cmd_write, busy, timeout;
  logic [23:0] cmd_addr;

  int tests_run = 0;
  int tests_failed = 0;
  int last_wait_cyc = 0;

  typedef struct {
    logic [2:0]  gnt;
    logic        wr;
    logic [23:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   rr_m;
  int   last_rd_m;

  sdram_port_arbiter dut (
    .iCLK(clk), .iRST_n(rst_n),
    .iWr_Req(wr_req), .iWr_Addr(wr_addr),
    .iRd_Req_1(rd_req_1), .iRd_Lvl_1(rd_lvl_1), .iRd_Addr_1(rd_addr_1),
    .iRd_Req_2(rd_req_2), .iRd_Lvl_2(rd_lvl_2), .iRd_Addr_2(rd_addr_2),
    .oGnt(gnt), .oCmd_Valid(cmd_valid), .iCmd_Ready(cmd_ready),
    .oCmd_Write(cmd_write), .oCmd_Addr(cmd_addr),
    .iBeat(beat), .oBusy(busy), .oTimeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    rr_m      = 0;
    last_rd_m = 2;
  endtask

  // Compute the expected winner from the current requests and push it to the scoreboard.
  task automatic predict();
    bit   u1, u2;
    bit   req[3];
    int   w;
    exp_t e;
    req[0] = wr_req;
    req[1] = rd_req_1;
    req[2] = rd_req_2;
    u1 = rd_req_1 && (rd_lvl_1 < 64);
    u2 = rd_req_2 && (rd_lvl_2 < 64);
    w  = -1;
    if (u1 && u2) w = (last_rd_m == 1) ? 2 : 1;
    else if (u1) w = 1;
    else if (u2) w = 2;
    else begin
      for (int k = 1; k <= 3; k++) begin
        int c = (rr_m + k) % 3;
        if (w < 0 && req[c]) w = c;
      end
    end
    e.gnt  = 3'd1 << w;
    e.wr   = (w == 0);
    e.addr = (w == 0) ? wr_addr : (w == 1) ? rd_addr_1 : rd_addr_2;
    sb_q.push_back(e);
    rr_m = w;
    if (w != 0) last_rd_m = w;
  endtask

  task automatic clear_reqs();
    wr_req   = 1'b0;
    rd_req_1 = 1'b0;
    rd_req_2 = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Wait (bounded) for oCmd_Valid, sampling on falling edges.
  task automatic wait_valid();
    last_wait_cyc = 0;
    do begin
      @(negedge clk);
      last_wait_cyc++;
    end while (!cmd_valid && last_wait_cyc < 20);
    if (!cmd_valid) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_valid: no oCmd_Valid after %0d cycles", last_wait_cyc);
    end
  endtask

  // Pop the expected grant and compare it with the issued command.
  task automatic check_cmd(input string name);
    exp_t e;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: command issued with empty scoreboard, gnt=%b", name, gnt);
    end else begin
      e = sb_q.pop_front();
      if (gnt !== e.gnt || cmd_write !== e.wr || cmd_addr !== e.addr || cmd_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s: got gnt=%b wr=%b addr=%h valid=%b, expected gnt=%b wr=%b addr=%h valid=1",
                 name, gnt, cmd_write, cmd_addr, cmd_valid, e.gnt, e.wr, e.addr);
      end
    end
  endtask

  // One full burst with iCmd_Ready=1: command check, then BL beats, then grant release.
  task automatic run_burst(input string name, input bit drop);
    logic [2:0] g;
    wait_valid();
    check_cmd(name);
    g = gnt;
    if (drop) clear_reqs();
    @(negedge clk);
    beat = 1'b1;
    repeat (BL - 1) @(negedge clk);
    tests_run++;
    if (gnt !== g || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_hold: got gnt=%b busy=%b before last beat, expected gnt=%b busy=1", name, gnt, busy, g);
    end
    @(negedge clk);
    beat = 1'b0;
    tests_run++;
    if (gnt !== 3'b000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_end: got gnt=%b busy=%b after last beat, expected gnt=000 busy=0", name, gnt, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_req = 1'b1; rd_req_1 = 1'b1; rd_req_2 = 1'b1;
    rd_lvl_1 = 9'd200; rd_lvl_2 = 9'd200;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (gnt !== 3'b000 || cmd_valid !== 1'b0 || cmd_write !== 1'b0 || cmd_addr !== 24'h0 ||
          busy !== 1'b0 || timeout !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_outputs: cycle %0d got gnt=%b valid=%b wr=%b addr=%h busy=%b to=%b, expected all 0",
                 i, gnt, cmd_valid, cmd_write, cmd_addr, busy, timeout);
      end
    end
    rst_n = 1'b1;
    model_reset();
    predict();
    run_burst("reset_first_grant", 1'b1);
    tests_run++;
    if (last_wait_cyc > 2) begin
      tests_failed++;
      $display("FAIL reset_latency: got %0d cycles to first grant, expected <= 2", last_wait_cyc);
    end
  endtask

  task automatic test_write_only();
    clear_reqs();
    wr_addr = 24'h000100;
    wr_req  = 1'b1;
    predict();
    run_burst("write_only", 1'b1);
    tests_run++;
    if (last_wait_cyc !== 1) begin
      tests_failed++;
      $display("FAIL write_latency: got %0d cycles, expected 1", last_wait_cyc);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    rd_lvl_1 = 9'd200; rd_lvl_2 = 9'd200;
    wr_addr = 24'h100000; rd_addr_1 = 24'h200000; rd_addr_2 = 24'h300000;
    wr_req = 1'b1; rd_req_1 = 1'b1; rd_req_2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      predict();
      run_burst($sformatf("round_robin_%0d", i), i == 5);
      tests_run++;
      if (last_wait_cyc !== 1) begin
        tests_failed++;
        $display("FAIL back_to_back_gap_%0d: got %0d cycles, expected 1", i, last_wait_cyc);
      end
    end
  endtask

  task automatic test_urgent();
    wr_addr = 24'h0A0000; rd_addr_1 = 24'h0B0000; rd_addr_2 = 24'h0C0000;
    // rd2 urgent, rd1 far above threshold
    wr_req = 1'b1; rd_req_1 = 1'b1; rd_lvl_1 = 9'd300; rd_req_2 = 1'b1; rd_lvl_2 = 9'd10;
    predict();
    run_burst("urgent_rd2", 1'b1);
    // both urgent twice: the reads alternate
    for (int i = 0; i < 2; i++) begin
      wr_req = 1'b1; rd_req_1 = 1'b1; rd_lvl_1 = 9'd5; rd_req_2 = 1'b1; rd_lvl_2 = 9'd5;
      predict();
      run_burst($sformatf("urgent_tie_%0d", i), 1'b1);
    end
    // threshold boundary: 64 is not urgent, 63 is
    wr_req = 1'b1; rd_req_1 = 1'b1; rd_lvl_1 = 9'd64; rd_req_2 = 1'b1; rd_lvl_2 = 9'd63;
    predict();
    run_burst("urgent_boundary_a", 1'b1);
    wr_req = 1'b1; rd_req_1 = 1'b1; rd_lvl_1 = 9'd63; rd_req_2 = 1'b1; rd_lvl_2 = 9'd64;
    predict();
    run_burst("urgent_boundary_b", 1'b1);
  endtask

  task automatic test_cmd_stall();
    cmd_ready = 1'b0;
    wr_addr = 24'h55AA00;
    wr_req  = 1'b1;
    predict();
    wait_valid();
    check_cmd("stall_cmd");
    clear_reqs();
    for (int i = 0; i < 20; i++) begin
      beat = i[0];
      @(negedge clk);
      tests_run++;
      if (cmd_valid !== 1'b1 || cmd_addr !== 24'h55AA00 || gnt !== 3'b001 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: got valid=%b addr=%h gnt=%b busy=%b, expected 1 55aa00 001 1",
                 i, cmd_valid, cmd_addr, gnt, busy);
      end
    end
    cmd_ready = 1'b1;
    beat = 1'b1;   // accepted together with a beat that must not count
    @(negedge clk);
    tests_run++;
    if (cmd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_accept: got valid=%b, expected 0", cmd_valid);
    end
    repeat (BL - 1) @(negedge clk);
    tests_run++;
    if (gnt !== 3'b001) begin
      tests_failed++;
      $display("FAIL stall_beats_7: got gnt=%b after 7 beats, expected 001", gnt);
    end
    @(negedge clk);
    beat = 1'b0;
    tests_run++;
    if (gnt !== 3'b000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_beats_8: got gnt=%b busy=%b, expected 000 0", gnt, busy);
    end
  endtask

  task automatic test_mid_reset();
    rd_addr_1 = 24'h123456; rd_lvl_1 = 9'd100;
    rd_req_1 = 1'b1;
    predict();
    wait_valid();
    check_cmd("mid_reset_cmd");
    @(negedge clk);
    beat = 1'b1;
    repeat (3) @(negedge clk);
    beat = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (gnt !== 3'b000 || cmd_valid !== 1'b0 || cmd_write !== 1'b0 || cmd_addr !== 24'h0 ||
        busy !== 1'b0 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got gnt=%b valid=%b wr=%b addr=%h busy=%b to=%b, expected all 0",
               gnt, cmd_valid, cmd_write, cmd_addr, busy, timeout);
    end
    clear_reqs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_watchdog();
    int cnt;
    wr_addr = 24'hABCDEF;
    wr_req  = 1'b1;
    predict();
    wait_valid();
    check_cmd("wdog_cmd");
    clear_reqs();
    @(negedge clk);
    beat = 1'b1;
    repeat (3) @(negedge clk);
    beat = 1'b0;
    cnt = 0;
`ifdef ARB_WDOG_EN
    do begin
      @(negedge clk);
      cnt++;
    end while (!timeout && cnt < 400);
    tests_run++;
    if (cnt !== 256 || gnt !== 3'b000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL wdog_timeout: got pulse after %0d cycles gnt=%b busy=%b, expected 256 000 0", cnt, gnt, busy);
    end
    @(negedge clk);
    tests_run++;
    if (timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL wdog_pulse_width: got oTimeout=%b, expected 0", timeout);
    end
`else
    repeat (300) begin
      @(negedge clk);
      if (timeout !== 1'b0) cnt++;
    end
    tests_run++;
    if (cnt !== 0 || gnt !== 3'b001 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL no_wdog_wait: got %0d timeout cycles gnt=%b busy=%b, expected 0 001 1", cnt, gnt, busy);
    end
    beat = 1'b1;
    repeat (BL - 3) @(negedge clk);
    beat = 1'b0;
    tests_run++;
    if (gnt !== 3'b000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_wdog_finish: got gnt=%b busy=%b, expected 000 0", gnt, busy);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    clear_reqs();
    wr_addr = 24'h0; rd_addr_1 = 24'h0; rd_addr_2 = 24'h0;
    rd_lvl_1 = 9'd0; rd_lvl_2 = 9'd0;
    cmd_ready = 1'b1;
    beat = 1'b0;
    model_reset();
    test_reset();
    test_write_only();
    test_round_robin();
    test_urgent();
    test_cmd_stall();
    test_mid_reset();
    test_watchdog();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
